// File: rtl/seq_add_ctrl.sv
// Saturating signed add/sub that reuses one SLICE-bit lookahead adder, LSB slice first; done pulses WIDTH/SLICE cycles after accept.
// Backpressure: start is taken only in IDLE/DONE and is ignored while busy; results hold until the next done.
module seq_add_ctrl #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  beff_r;
    logic [WIDTH-1:0]  partial;
    logic              carry;
    logic [IDXW-1:0]   idx;

    logic [SLICE-1:0]  sa;
    logic [SLICE-1:0]  sb;
    logic [SLICE-1:0]  g;
    logic [SLICE-1:0]  p;
    logic [SLICE-1:0]  ssum;
    logic [SLICE:0]    c;
    logic              cn;
    logic              pp;
    logic [WIDTH-1:0]  raw;
    logic [WIDTH-1:0]  sat;
    logic              ovf;
    logic              last;

    // Each carry is expanded straight from the slice generates/propagates and
    // carry-in, so the shared slice has no internal ripple path.
    always_comb begin
        sa   = a_r[idx*SLICE +: SLICE];
        sb   = beff_r[idx*SLICE +: SLICE];
        g    = sa & sb;
        p    = sa ^ sb;
        c    = '0;
        cn   = 1'b0;
        pp   = 1'b0;
        c[0] = carry;
        for (int i = 0; i < SLICE; i++) begin
            cn = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                cn = cn | (pp & g[j]);
                pp = pp & p[j];
            end
            cn       = cn | (pp & carry);
            c[i+1]   = cn;
        end
        ssum = p ^ c[SLICE-1:0];
        raw  = partial;
        raw[idx*SLICE +: SLICE] = ssum;
    end

    always_comb begin
        last = (idx == IDXW'(NSLICE - 1));
        ovf  = (a_r[WIDTH-1] == beff_r[WIDTH-1]) && (raw[WIDTH-1] != a_r[WIDTH-1]);
        if (ovf)
            sat = a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            sat = raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            a_r     <= '0;
            beff_r  <= '0;
            partial <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            flag_n  <= 1'b0;
            flag_z  <= 1'b0;
            flag_v  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        beff_r  <= op_sub ? ~b : b;
                        carry   <= op_sub;
                        idx     <= '0;
                        partial <= '0;
                        busy    <= 1'b1;
                        state   <= S_RUN;
                    end else begin
                        state   <= S_IDLE;
                    end
                end
                S_RUN: begin
                    partial <= raw;
                    carry   <= c[SLICE];
                    if (last) begin
                        result <= sat;
                        flag_v <= ovf;
                        flag_n <= sat[WIDTH-1];
                        flag_z <= (sat == '0);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        idx    <= idx + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
